// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Multi-cycle RV32M/RV64M execute unit covering MUL, MULH,
//             MULHSU, MULHU, DIV, DIVU, REM and REMU behind a valid/ready
//             handshake. Multiply is an iterative shift-add over a
//             2*XLEN-bit product; divide is radix-2 restoring on magnitudes.
//             Divide-by-zero and signed overflow are resolved at accept
//             without iterating.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             flush           - abort in-flight op, discard pending result
//             in_valid/in_ready, op, a, b   - request side
//             out_valid/out_ready, result   - response side
//             busy            - operation in progress (state != IDLE)
//  Options  : FAST_MUL_EN     - when defined, MUL-class ops use a single-cycle
//                               multiplier at accept and go straight to DONE.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int            c_pw  = 2 * XLEN;
    localparam logic [XLEN-1:0] c_min = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_result;
    // Multiply datapath
    logic [c_pw-1:0]     r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [c_pw-1:0]     r_prod;
    logic                r_b_signed;
    // Divide datapath
    logic [XLEN-1:0]     r_divisor;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_quo;
    logic                r_neg_q;
    logic                r_neg_r;
    // Result selector: high product half for MULH*, remainder for REM*
    logic                r_pick;

    // ------------------------------------------------------------------
    // Accept-time decode
    // ------------------------------------------------------------------
    logic            w_is_div;
    logic            w_div_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_mul_a_signed;
    logic            w_mul_b_signed;
    logic [c_pw-1:0] w_a_ext;
    logic            w_pick;

    assign w_is_div       = op[2];
    assign w_div_signed   = ~op[0];
    assign w_a_neg        = w_div_signed & a[XLEN-1];
    assign w_b_neg        = w_div_signed & b[XLEN-1];
    assign w_a_mag        = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag        = w_b_neg ? (~b + 1'b1) : b;
    assign w_b_zero       = (b == '0);
    assign w_ovf          = w_div_signed & (a == c_min) & (b == '1);
    assign w_special      = w_is_div & (w_b_zero | w_ovf);
    assign w_mul_a_signed = (op[1:0] == 2'b01) | (op[1:0] == 2'b10);
    assign w_mul_b_signed = (op[1:0] == 2'b01);
    assign w_a_ext        = {{XLEN{w_mul_a_signed & a[XLEN-1]}}, a};
    assign w_pick         = w_is_div ? op[1] : (op[1:0] != 2'b00);

    always_comb begin
        w_special_res = '0;
        if (w_b_zero) begin
            w_special_res = op[1] ? a : '1;
        end else if (w_ovf) begin
            w_special_res = op[1] ? '0 : c_min;
        end
    end

`ifdef FAST_MUL_EN
    logic [c_pw-1:0] w_b_ext;
    logic [c_pw-1:0] w_fast_prod;
    assign w_b_ext     = {{XLEN{w_mul_b_signed & b[XLEN-1]}}, b};
    assign w_fast_prod = w_a_ext * w_b_ext;
`endif

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic            w_last;
    logic [c_pw-1:0] w_addend;
    logic [c_pw-1:0] w_prod_next;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;

    assign w_last   = (r_cnt == CNT_W'(XLEN - 1));
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    // The multiplier MSB of a signed operand weighs -2^(XLEN-1), so the
    // final partial product is subtracted rather than added.
    assign w_prod_next = (w_last & r_b_signed) ? (r_prod - w_addend)
                                               : (r_prod + w_addend);

    // Remainder stays below the divisor, so the shifted value fits XLEN+1.
    assign w_shift    = {r_rem, r_quo[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_next = {r_quo[XLEN-2:0], w_ge};
    assign w_q_fix    = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_r_fix    = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_result   <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_b_signed <= 1'b0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_pick     <= 1'b0;
        end else if (flush) begin
            // Result register deliberately left untouched.
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cnt  <= '0;
                        r_pick <= w_pick;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else if (w_is_div) begin
                            r_rem     <= '0;
                            r_quo     <= w_a_mag;
                            r_divisor <= w_b_mag;
                            r_neg_q   <= w_a_neg ^ w_b_neg;
                            r_neg_r   <= w_a_neg;
                            r_state   <= S_DIV;
                        end else begin
`ifdef FAST_MUL_EN
                            r_result <= w_pick ? w_fast_prod[c_pw-1:XLEN]
                                               : w_fast_prod[XLEN-1:0];
                            r_state  <= S_DONE;
`else
                            r_mcand    <= w_a_ext;
                            r_mplier   <= b;
                            r_prod     <= '0;
                            r_b_signed <= w_mul_b_signed;
                            r_state    <= S_MUL;
`endif
                        end
                    end
                end
                S_MUL: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= {r_mcand[c_pw-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= r_pick ? w_prod_next[c_pw-1:XLEN]
                                           : w_prod_next[XLEN-1:0];
                        r_state  <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // Sign correction folded into the DONE transition.
                        r_result <= r_pick ? w_r_fix : w_q_fix;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake outputs are pure decodes of the state register.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Directed self-checking bench for muldiv_unit (XLEN=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

`ifdef FAST_MUL_EN
    localparam int c_mul_lat = 1;
`else
    localparam int c_mul_lat = XLEN + 1;
`endif
    localparam int c_div_lat = XLEN + 1;

    localparam logic [2:0] c_mul    = 3'b000;
    localparam logic [2:0] c_mulh   = 3'b001;
    localparam logic [2:0] c_mulhsu = 3'b010;
    localparam logic [2:0] c_mulhu  = 3'b011;
    localparam logic [2:0] c_div    = 3'b100;
    localparam logic [2:0] c_divu   = 3'b101;
    localparam logic [2:0] c_rem    = 3'b110;
    localparam logic [2:0] c_remu   = 3'b111;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op = '0;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] o, input logic [XLEN-1:0] x,
                            input logic [XLEN-1:0] y);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Returns the cycle offset from the accept cycle at which out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                          input logic [XLEN-1:0] exp, input int exp_lat);
        int lat;
        start_op(o, x, y);
        wait_valid(lat);
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, " result"}, 64'(result), 64'(exp));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq({tag, " in_ready after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int bad;

        repeat (3) step();
        rst = 1'b0;
        check_eq("reset out_valid", 64'(out_valid), 64'd0);
        check_eq("reset result", 64'(result), 64'd0);
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset in_ready", 64'(in_ready), 64'd1);

        // Divide, signed and unsigned
        run_op("DIV -7/2",   c_div,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, c_div_lat);
        run_op("REM -7/2",   c_rem,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, c_div_lat);
        run_op("DIV 100/-7", c_div,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, c_div_lat);
        run_op("REM 100/-7", c_rem,  32'd100, 32'hFFFF_FFF9, 32'd2, c_div_lat);
        run_op("REMU 100/7", c_remu, 32'd100, 32'd7, 32'd2, c_div_lat);
        run_op("DIVU max/1", c_divu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, c_div_lat);

        // Special cases resolved at accept
        run_op("DIVU by 0", c_divu, 32'h0000_0064, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("REMU by 0", c_remu, 32'h0000_0064, 32'd0, 32'h0000_0064, 1);
        run_op("DIV by 0",  c_div,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("REM by 0",  c_rem,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1);
        run_op("DIV ovf",   c_div,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM ovf",   c_rem,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Multiply
        run_op("MULHSU -1*max", c_mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c_mul_lat);
        run_op("MULHU max*max", c_mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, c_mul_lat);
        run_op("MUL max*max",   c_mul,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, c_mul_lat);
        run_op("MULH -2*3",     c_mulh,   32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, c_mul_lat);
        run_op("MUL -2*3",      c_mul,    32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, c_mul_lat);
        run_op("MULH min*min",  c_mulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, c_mul_lat);
        run_op("MULH -1*-1",    c_mulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, c_mul_lat);

        // Result held under back-pressure
        start_op(c_divu, 32'd100, 32'd7);
        wait_valid(lat);
        check_eq("hold latency", 64'(lat), 64'(c_div_lat));
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (result !== 32'h0000_000E || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
            step();
        end
        check_eq("hold stable cycles bad", 64'(bad), 64'd0);
        check_eq("hold result", 64'(result), 64'h0000_000E);
        out_ready = 1'b1;
        check_eq("consume cycle in_ready", 64'(in_ready), 64'd0);
        step();
        out_ready = 1'b0;
        check_eq("post consume in_ready", 64'(in_ready), 64'd1);
        check_eq("post consume out_valid", 64'(out_valid), 64'd0);

        // Flush mid-divide
        start_op(c_div, 32'hFFFF_FFF9, 32'd2);
        check_eq("flush div busy", 64'(busy), 64'd1);
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (out_valid !== 1'b0) bad++;
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush no early valid", 64'(bad), 64'd0);
        check_eq("flush in_ready", 64'(in_ready), 64'd1);
        check_eq("flush out_valid", 64'(out_valid), 64'd0);
        check_eq("flush busy", 64'(busy), 64'd0);
        check_eq("flush result kept", 64'(result), 64'h0000_000E);
        run_op("MUL 3*5", c_mul, 32'd3, 32'd5, 32'h0000_000F, c_mul_lat);

        // Request presented together with flush is not accepted
        op       = c_div;
        a        = 32'd9;
        b        = 32'd3;
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("flush blocks accept", 64'(busy), 64'd0);

        // Reset mid-divide
        start_op(c_div, 32'hFFFF_FFF9, 32'd2);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst result", 64'(result), 64'd0);
        check_eq("midrst busy", 64'(busy), 64'd0);
        check_eq("midrst in_ready", 64'(in_ready), 64'd1);
        run_op("DIVU 100/7 after rst", c_divu, 32'd100, 32'd7, 32'h0000_000E, c_div_lat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
